branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Dynamic branch predictor for the RV64I fetch stage. It is the front-end counterpart of the branch resolution logic.
- Fetch queries it each cycle with the PC and receives a taken/not-taken guess plus a next-PC target.
- Execute feeds back each resolved conditional branch (actual direction and target) to train the tables.
- Storage: direct-mapped table of 2-bit saturating counters plus a tagged branch target buffer (BTB).

Parameters:
- ENTRIES, 64, number of table entries; power of 2, minimum 4.
- TAG_W, 16, number of PC tag bits stored per entry.
- XLEN, 64, PC and target width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- lookup_valid  input  1  fetch is presenting lookup_pc this cycle.
- lookup_pc  input  XLEN  PC of the instruction being fetched.
- pred_hit  output  1  lookup_pc matches a valid BTB entry.
- pred_taken  output  1  predicted taken.
- pred_target  output  XLEN  predicted next PC.
- update_valid  input  1  one resolved conditional branch this cycle.
- update_pc  input  XLEN  PC of the resolved branch.
- update_taken  input  1  actual branch outcome.
- update_target  input  XLEN  actual taken target (rs1-independent, PC+imm).
- update_pred_taken  input  1  prediction originally made for this branch; used only with BP_STATS_EN.

Behaviour:
- Indexing: idx = pc[log2(ENTRIES)+1:2]; tag = pc[log2(ENTRIES)+TAG_W+1 : log2(ENTRIES)+2]. pc[1:0] is ignored.
- Per-entry state:
  - valid (1 bit)
  - tag (TAG_W bits)
  - target (XLEN bits)
  - ctr (2 bits): 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Reset (async, rst_n=0):
  - All valid=0, all ctr=01, tags and targets=0.
  - Outputs settle to pred_hit=0, pred_taken=0, pred_target=lookup_pc+4.
  - An assertion mid-update discards that update; no partial entry write.
- Lookup (combinational from registered state, zero-cycle latency):
  - hit = valid[idx] & (tag[idx]==tag(lookup_pc)).
  - pred_hit = lookup_valid & hit.
  - pred_taken = pred_hit & ctr[idx][1].
  - pred_target = pred_taken ? target[idx] : lookup_pc+4, with 64-bit wrap-around add.
  - lookup_valid=0 forces pred_hit=0 and pred_taken=0; pred_target is still lookup_pc+4.
- Update (registered, visible to lookups the cycle after update_valid):
  - Miss (invalid or tag mismatch): allocate/replace. valid=1, tag written; ctr=10 if taken else 01; target=update_target if taken, else unchanged-on-replace = update_target.
  - Hit, taken: ctr saturating increment (11 stays 11); target=update_target.
  - Hit, not taken: ctr saturating decrement (00 stays 00); target unchanged.
  - update_valid=0: no state change.
- Simultaneous lookup and update to the same index in one cycle: lookup returns pre-update state. No bypass.
- Different indices: fully independent. One update per cycle maximum.
- Aliasing: no disambiguation beyond TAG_W bits. A tag-colliding PC is accepted as a hit.

Optional Feature:
- Macro: BP_STATS_EN.
- Defined: adds outputs stat_updates [31:0] and stat_mispredicts [31:0].
  - Both reset to 0.
  - stat_updates increments on every update_valid.
  - stat_mispredicts increments when update_valid & (update_pred_taken != update_taken).
  - Both counters wrap at 2^32-1 -> 0.
- Undefined: counters and outputs absent; update_pred_taken is unused.

Test Plan:
- After reset, lookup_valid=1, lookup_pc=0x1000 -> pred_hit=0, pred_taken=0, pred_target=0x1004.
- Update pc=0x1000 taken target=0x0F00; next cycle lookup 0x1000 -> pred_hit=1, pred_taken=1 (ctr=10), pred_target=0x0F00.
- Train pc=0x2000 with three taken updates, then two not-taken -> ctr sequence 10,11,11,10,01. Final lookup gives pred_hit=1, pred_taken=0, pred_target=0x2004.
- Index alias, ENTRIES=64:
  - Train 0x1000 taken to 0x0F00.
  - Update 0x1100 (same idx, different tag) not taken -> lookup 0x1000 gives pred_hit=0.
  - Lookup 0x1100 gives pred_hit=1, pred_taken=0.
- Same-cycle lookup and update of 0x3000 (previously ctr=01), update taken -> that cycle pred_taken=0; next cycle pred_taken=1.
- BP_STATS_EN:
  - Five updates, two with update_pred_taken != update_taken -> stat_updates=5, stat_mispredicts=2.
  - Pulsing rst_n low mid-sequence -> both counters and the table return to reset values immediately.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit-counter branch predictor with tagged BTB for the RV64I fetch stage.
// Optional update/mispredict statistics counters are enabled with `define BP_STATS_EN.
module branch_predictor #(
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 16,
  parameter int XLEN    = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            lookup_valid,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            update_valid,
  input  logic [XLEN-1:0] update_pc,
  input  logic            update_taken,
  input  logic [XLEN-1:0] update_target,
  input  logic            update_pred_taken
`ifdef BP_STATS_EN
  ,
  output logic [31:0]     stat_updates,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_LO = IDX_W + 2;
  localparam int TAG_HI = IDX_W + TAG_W + 1;

  logic              tbl_valid  [ENTRIES];
  logic [TAG_W-1:0]  tbl_tag    [ENTRIES];
  logic [XLEN-1:0]   tbl_target [ENTRIES];
  logic [1:0]        tbl_ctr    [ENTRIES];

  logic [IDX_W-1:0]  l_idx, u_idx;
  logic [TAG_W-1:0]  l_tag, u_tag;
  logic              l_hit, u_hit;
  logic [1:0]        u_ctr, ctr_next;

  assign l_idx = lookup_pc[IDX_W+1:2];
  assign l_tag = lookup_pc[TAG_HI:TAG_LO];
  assign u_idx = update_pc[IDX_W+1:2];
  assign u_tag = update_pc[TAG_HI:TAG_LO];

  // Lookup reads only registered state, so a same-cycle update is not bypassed.
  assign l_hit       = tbl_valid[l_idx] && (tbl_tag[l_idx] == l_tag);
  assign pred_hit    = lookup_valid && l_hit;
  assign pred_taken  = pred_hit && tbl_ctr[l_idx][1];
  assign pred_target = pred_taken ? tbl_target[l_idx] : lookup_pc + XLEN'(4);

  assign u_hit = tbl_valid[u_idx] && (tbl_tag[u_idx] == u_tag);
  assign u_ctr = tbl_ctr[u_idx];

  always_comb begin
    ctr_next = u_ctr;
    if (!u_hit)
      ctr_next = update_taken ? 2'b10 : 2'b01;
    else if (update_taken && (u_ctr != 2'b11))
      ctr_next = u_ctr + 2'b01;
    else if (!update_taken && (u_ctr != 2'b00))
      ctr_next = u_ctr - 2'b01;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_valid[i]  <= 1'b0;
        tbl_tag[i]    <= '0;
        tbl_target[i] <= '0;
        tbl_ctr[i]    <= 2'b01;
      end
    end else if (update_valid) begin
      tbl_valid[u_idx] <= 1'b1;
      tbl_tag[u_idx]   <= u_tag;
      tbl_ctr[u_idx]   <= ctr_next;
      // A not-taken hit keeps the learned target; allocation always loads it.
      if (!u_hit || update_taken)
        tbl_target[u_idx] <= update_target;
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_updates     <= '0;
      stat_mispredicts <= '0;
    end else if (update_valid) begin
      stat_updates <= stat_updates + 32'd1;
      if (update_pred_taken != update_taken)
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`else
  logic unused_pred_taken;
  assign unused_pred_taken = update_pred_taken;
`endif

  // PC bits outside index and tag do not take part in prediction.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[XLEN-1:TAG_HI+1], lookup_pc[1:0],
                            update_pc[XLEN-1:TAG_HI+1], update_pc[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios plus random traffic scored against a table model.
// Build with +define+BP_STATS_EN to also score the statistics counters.
module tb_branch_predictor;
  localparam int ENTRIES = 64;
  localparam int TAG_W   = 16;
  localparam int XLEN    = 64;
  localparam int IW      = $clog2(ENTRIES);
`ifdef BP_STATS_EN
  localparam int EW = 2 + XLEN + 64;
`else
  localparam int EW = 2 + XLEN;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            lookup_valid = 1'b0;
  logic [XLEN-1:0] lookup_pc = '0;
  logic            pred_hit, pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            update_valid = 1'b0;
  logic [XLEN-1:0] update_pc = '0;
  logic            update_taken = 1'b0;
  logic [XLEN-1:0] update_target = '0;
  logic            update_pred_taken = 1'b0;
`ifdef BP_STATS_EN
  logic [31:0]     stat_updates, stat_mispredicts;
`endif

  branch_predictor #(.ENTRIES(ENTRIES), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
    .update_target(update_target), .update_pred_taken(update_pred_taken)
`ifdef BP_STATS_EN
    , .stat_updates(stat_updates), .stat_mispredicts(stat_mispredicts)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: the predictor as a table keyed by index
  bit              m_valid [ENTRIES];
  longint unsigned m_tag   [ENTRIES];
  logic [XLEN-1:0] m_tgt   [ENTRIES];
  int              m_ctr   [ENTRIES];
  longint unsigned m_updates, m_mispred;

  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int checks = 0;
  int errors = 0;
  bit stim_done = 1'b0;

  function automatic int idx_of(logic [XLEN-1:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic longint unsigned tag_of(logic [XLEN-1:0] pc);
    return longint'((pc >> (IW + 2)) % (64'd1 << TAG_W));
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = '0; m_ctr[i] = 1;
    end
    m_updates = 0; m_mispred = 0;
  endfunction

  function automatic logic [EW-1:0] model_lookup(bit lv, logic [XLEN-1:0] pc);
    int i = idx_of(pc);
    bit hit = lv && m_valid[i] && (m_tag[i] == tag_of(pc));
    bit tk  = hit && (m_ctr[i] >= 2);
    logic [XLEN-1:0] tgt = tk ? m_tgt[i] : pc + 4;
`ifdef BP_STATS_EN
    return {hit, tk, tgt, 32'(m_updates), 32'(m_mispred)};
`else
    return {hit, tk, tgt};
`endif
  endfunction

  function automatic void model_update(logic [XLEN-1:0] pc, bit t, logic [XLEN-1:0] tgt, bit pt);
    int i = idx_of(pc);
    if (!(m_valid[i] && m_tag[i] == tag_of(pc))) begin
      m_valid[i] = 1; m_tag[i] = tag_of(pc); m_ctr[i] = t ? 2 : 1; m_tgt[i] = tgt;
    end else if (t) begin
      m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3; m_tgt[i] = tgt;
    end else begin
      m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
    end
    m_updates++;
    if (pt != t) m_mispred++;
  endfunction

  // driver: one cycle of stimulus; expected response queued before model advances
  task automatic cycle(input string nm, input bit lv, input logic [XLEN-1:0] lpc,
                       input bit uv, input logic [XLEN-1:0] upc, input bit ut,
                       input logic [XLEN-1:0] utgt, input bit upt, input bit rst_pulse);
    @(posedge clk); #1;
    rst_n = 1'b1;
    lookup_valid = lv; lookup_pc = lpc;
    update_valid = uv; update_pc = upc; update_taken = ut;
    update_target = utgt; update_pred_taken = upt;
    if (rst_pulse) begin
      rst_n = 1'b0;
      model_reset();
    end
    exp_q.push_back(model_lookup(lv, lpc));
    name_q.push_back(nm);
    if (uv && !rst_pulse) model_update(upc, ut, utgt, upt);
  endtask

  task automatic look(input string nm, input logic [XLEN-1:0] pc);
    cycle(nm, 1, pc, 0, '0, 0, '0, 0, 0);
  endtask

  task automatic upd(input string nm, input logic [XLEN-1:0] pc, input bit t,
                     input logic [XLEN-1:0] tgt, input bit pt);
    cycle(nm, 1, pc, 1, pc, t, tgt, pt, 0);
  endtask

  // scoreboard monitor: compare DUT outputs mid-cycle against queued expectations
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [EW-1:0] e, g;
      string nm;
      e = exp_q.pop_front();
      nm = name_q.pop_front();
`ifdef BP_STATS_EN
      g = {pred_hit, pred_taken, pred_target, stat_updates, stat_mispredicts};
`else
      g = {pred_hit, pred_taken, pred_target};
`endif
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s got=%h expected=%h", nm, g, e);
      end
    end
  end

  initial begin
    logic [XLEN-1:0] pc, lpc, tgt;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    look("reset_lookup", 64'h1000);
    cycle("lookup_invalid", 0, 64'h1000, 0, '0, 0, '0, 0, 0);
    upd("alloc_taken", 64'h1000, 1, 64'h0F00, 0);
    look("hit_taken", 64'h1000);

    upd("train_t1", 64'h2000, 1, 64'h2400, 0);
    upd("train_t2", 64'h2000, 1, 64'h2400, 1);
    upd("train_t3", 64'h2000, 1, 64'h2400, 1);
    upd("train_n1", 64'h2000, 0, 64'h0, 1);
    upd("train_n2", 64'h2000, 0, 64'h0, 1);
    look("train_final", 64'h2000);

    upd("alias_replace", 64'h1100, 0, 64'h5555, 1);
    look("alias_old_miss", 64'h1000);
    look("alias_new_hit", 64'h1100);
    look("alias_tag_collide", 64'hABCD_0000_0000_1101);

    upd("same_cyc_alloc", 64'h3000, 0, 64'h0, 0);
    upd("same_cyc_pre", 64'h3000, 1, 64'h3F00, 0);
    look("same_cyc_post", 64'h3000);
    look("wrap_add", 64'hFFFF_FFFF_FFFF_FFFE);

    // random traffic over a small PC pool to exercise hits, aliases and saturation
    for (int n = 0; n < 400; n++) begin
      pc  = (64'($urandom) << 24) | (64'($urandom_range(0, 2)) << 8)
          | (64'($urandom_range(0, 7)) << 2) | 64'($urandom_range(0, 3));
      lpc = ($urandom_range(0, 3) == 0) ? pc
          : (64'($urandom_range(0, 2)) << 8) | (64'($urandom_range(0, 7)) << 2);
      tgt = {32'($urandom), 32'($urandom)};
      cycle("random", $urandom_range(0, 4) != 0, lpc, $urandom_range(0, 1) == 1, pc,
            $urandom_range(0, 1) == 1, tgt, $urandom_range(0, 1) == 1, 0);
    end

    // reset asserted while an update is presented: update is discarded
    upd("pre_reset_train", 64'h1000, 1, 64'h0F00, 1);
    cycle("reset_mid_update", 1, 64'h1000, 1, 64'h1000, 1, 64'h0F00, 0, 1);
    look("after_reset", 64'h1000);
    upd("post_reset_alloc", 64'h1000, 0, 64'h0, 1);
    look("post_reset_hit", 64'h1000);
    cycle("idle", 0, 64'h0, 0, '0, 0, '0, 0, 0);

    // drain with a bounded wait
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
    end
    stim_done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
